// File: rtl/ks_sub_pipe.sv
// Three-stage handshaked Kogge-Stone subtractor: A - B - bin computed as A + ~B + ~bin.
// Optional saturating signed mode (adds port i_sat) when KS_SUB_SAT_EN is defined.
module ks_sub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
`ifdef KS_SUB_SAT_EN
  input  logic             i_sat,
`endif
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf
);

  localparam int unsigned L   = $clog2(WIDTH);
  localparam int unsigned L1  = (L + 1) / 2;
  localparam int unsigned MSB = WIDTH - 1;

  if (LAT != 3) begin : g_lat_chk
    $error("ks_sub_pipe: LAT is fixed at 3");
  end
  if (WIDTH < 8 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_chk
    $error("ks_sub_pipe: WIDTH must be a power of two in 8..32");
  end

  logic             rst_q;
  logic             advance;
  logic             accept;

  logic             s1_v, s1_c0, s1_am, s1_bm, s1_sat;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s2_v, s2_c0, s2_am, s2_bm, s2_sat;
  logic [WIDTH-1:0] s2_p, s2_g, s2_ps;

  logic [WIDTH-1:0] pg [0:L];
  logic [WIDTH-1:0] pp [0:L-1];

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             ovf_c;
  logic             sat_c;

  // Whole pipe moves as one unit; input side closed for the cycle after reset.
  assign advance    = ~o_valid | i_out_ready;
  assign o_in_ready = advance & ~rst_q;
  assign accept     = i_valid & o_in_ready;

`ifdef KS_SUB_SAT_EN
  assign sat_c = i_sat;
`else
  assign sat_c = 1'b0;
`endif

  // Borrow-in (as carry c0) folded into bit 0 so G[i] is the carry into bit i+1.
  assign pg[0] = {s1_g[WIDTH-1:1], s1_g[0] | (s1_p[0] & s1_c0)};
  assign pp[0] = s1_p;

  // Prefix levels 1..L1 in stage 2, L1+1..L in stage 3 (fed from stage-2 registers).
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned D = 1 << (k - 1);
    logic [WIDTH-1:0] gs, ps, gn;

    if (k == L1 + 1) begin : g_src_reg
      assign gs = s2_g;
      assign ps = s2_p;
    end else begin : g_src_comb
      assign gs = pg[k-1];
      assign ps = pp[k-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_black
        assign gn[i] = gs[i] | (ps[i] & gs[i-D]);
      end else begin : g_pass
        assign gn[i] = gs[i];
      end
    end
    assign pg[k] = gn;

    if (k < L) begin : g_prop
      logic [WIDTH-1:0] pn;
      for (genvar i = 0; i < WIDTH; i++) begin : g_pbit
        if (i >= D) begin : g_and
          assign pn[i] = ps[i] & ps[i-D];
        end else begin : g_keep
          assign pn[i] = ps[i];
        end
      end
      assign pp[k] = pn;
    end
  end

  // Stage-3 sum, overflow and optional clamp ahead of the output registers.
  always_comb begin
    sum_c  = s2_ps ^ {pg[L][WIDTH-2:0], s2_c0};
    ovf_c  = (s2_am != s2_bm) && (sum_c[MSB] != s2_am);
    diff_c = sum_c;
    if (s2_sat && ovf_c) begin
      diff_c = s2_am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Valid bits and outputs: cleared by reset, shifted on advance.
  always_ff @(posedge i_clk) begin
    rst_q <= i_rst;
    if (i_rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      o_valid <= 1'b0;
      o_diff  <= '0;
      o_bout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (advance) begin
      s1_v    <= accept;
      s2_v    <= s1_v;
      o_valid <= s2_v;
      o_diff  <= diff_c;
      o_bout  <= ~pg[L][MSB];
      o_ovf   <= ovf_c;
    end
  end

  // Data registers: contents are don't-care while the matching valid bit is low.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      s1_p   <= i_a ^ ~i_b;
      s1_g   <= i_a & ~i_b;
      s1_c0  <= ~i_bin;
      s1_am  <= i_a[MSB];
      s1_bm  <= i_b[MSB];
      s1_sat <= sat_c;
      s2_g   <= pg[L1];
      s2_p   <= pp[L1];
      s2_ps  <= s1_p;
      s2_c0  <= s1_c0;
      s2_am  <= s1_am;
      s2_bm  <= s1_bm;
      s2_sat <= s1_sat;
    end
  end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe: directed vectors with hand-computed results.
// Build with +define+KS_SUB_SAT_EN to exercise the saturating mode.
module tb_ks_sub_pipe;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         sat;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [W-1:0] dsat;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         i_clk, i_rst, i_valid, o_in_ready, i_bin;
  logic         o_valid, i_out_ready, o_bout, o_ovf;
  logic [W-1:0] i_a, i_b, o_diff;
`ifdef KS_SUB_SAT_EN
  logic         i_sat;
`endif

  vec_t vt [16];
  exp_t sb [$];
  int   cur;
  int   n_cmp;
  int   n_fail;
  int   n_out;

  ks_sub_pipe #(.WIDTH(W), .LAT(3)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_bin       (i_bin),
`ifdef KS_SUB_SAT_EN
    .i_sat       (i_sat),
`endif
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_diff      (o_diff),
    .o_bout      (o_bout),
    .o_ovf       (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input int idx);
    exp_t e;
    e.diff = vt[idx].diff;
`ifdef KS_SUB_SAT_EN
    if (vt[idx].sat) e.diff = vt[idx].dsat;
`endif
    e.bout = vt[idx].bout;
    e.ovf  = vt[idx].ovf;
    return e;
  endfunction

  // Scoreboard push: expected result queued at the moment a beat is accepted.
  always @(negedge i_clk) begin
    if (!i_rst && i_valid && o_in_ready) sb.push_back(expect_of(cur));
  end

  // Monitor: every consumed result is popped and compared.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got diff=0x%0h, expected no result", o_diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(o_diff), 32'(e.diff));
        check("bout", 32'(o_bout), 32'(e.bout));
        check("ovf",  32'(o_ovf),  32'(e.ovf));
      end
    end
  end

  task automatic send(input int idx);
    logic ok;
    @(posedge i_clk); #1;
    cur     = idx;
    i_a     = vt[idx].a;
    i_b     = vt[idx].b;
    i_bin   = vt[idx].bin;
`ifdef KS_SUB_SAT_EN
    i_sat   = vt[idx].sat;
`endif
    i_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge i_clk);
      ok = o_in_ready;
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge i_clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // a, b, bin, sat, diff, bout, ovf, saturated diff
    vt[0]  = '{16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h1000};
    vt[1]  = '{16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    vt[2]  = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 16'h8000};
    vt[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h7FFF};
    vt[6]  = '{16'h0100, 16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[7]  = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 16'h9999};
    vt[8]  = '{16'h1234, 16'hABCD, 1'b0, 1'b0, 16'h6667, 1'b1, 1'b0, 16'h6667};
    vt[9]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    vt[10] = '{16'h7FFF, 16'h8000, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF};
    vt[11] = '{16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0001};
    vt[12] = '{16'hC000, 16'h4001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF};
    vt[13] = '{16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hAAAB, 1'b1, 1'b1, 16'hAAAB};
    vt[14] = '{16'hFFFE, 16'h0001, 1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 16'hFFFC};
    vt[15] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};

    n_cmp = 0; n_fail = 0; n_out = 0; cur = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1;
    i_a = '0; i_b = '0; i_bin = 1'b0;
`ifdef KS_SUB_SAT_EN
    i_sat = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid",    32'(o_valid),    32'd0);
    check("rst_diff",     32'(o_diff),     32'd0);
    check("rst_bout",     32'(o_bout),     32'd0);
    check("rst_ovf",      32'(o_ovf),      32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("in_ready_after_rst", 32'(o_in_ready), 32'd1);

    // Latency: o_valid rises three cycles after the beat is presented.
    send(0);
    check("lat_c0", 32'(o_valid), 32'd0);
    idle();
    @(negedge i_clk); check("lat_c1", 32'(o_valid), 32'd0);
    @(negedge i_clk); check("lat_c2", 32'(o_valid), 32'd0);
    @(negedge i_clk); check("lat_c3", 32'(o_valid), 32'd1);
    drain();

    // Borrow/wrap and signed-overflow corners as isolated beats.
    for (int i = 1; i <= 3; i++) begin
      send(i);
      idle();
    end
    drain();

    // Eight back-to-back beats produce eight consecutive valid cycles.
    fork
      begin
        for (int i = 4; i <= 11; i++) send(i);
        idle();
      end
      begin
        for (int t = 0; t < 20 && !o_valid; t++) @(negedge i_clk);
        check("stream_v0", 32'(o_valid), 32'd1);
        for (int k = 1; k < 8; k++) begin
          @(negedge i_clk);
          check("stream_v", 32'(o_valid), 32'd1);
        end
        @(negedge i_clk);
        check("stream_end", 32'(o_valid), 32'd0);
      end
    join
    drain();

    // Full pipe held under backpressure for four cycles.
    @(posedge i_clk); #1 i_out_ready = 1'b0;
    fork
      begin
        for (int i = 12; i <= 15; i++) send(i);
        idle();
      end
      begin
        for (int t = 0; t < 20 && !o_valid; t++) @(negedge i_clk);
        for (int k = 0; k < 4; k++) begin
          if (k != 0) @(negedge i_clk);
          check("stall_valid", 32'(o_valid),    32'd1);
          check("stall_ready", 32'(o_in_ready), 32'd0);
          check("stall_diff",  32'(o_diff),     32'h7FFF);
          check("stall_ovf",   32'(o_ovf),      32'd1);
        end
        @(posedge i_clk); #1 i_out_ready = 1'b1;
      end
    join
    drain();
    check("out_count", 32'(n_out), 32'd16);

    // Reset with three beats in flight: nothing stale may emerge.
    @(posedge i_clk); #1 i_out_ready = 1'b0;
    for (int i = 0; i <= 2; i++) send(i);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    sb.delete();
    @(posedge i_clk); #1;
    i_rst       = 1'b0;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    check("midrst_valid", 32'(o_valid),    32'd0);
    check("midrst_ready", 32'(o_in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("midrst_no_stale", 32'(o_valid), 32'd0);
    end
    send(13);
    idle();
    drain();
    check("out_count_final", 32'(n_out), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
